fifo_buf: RTL and testbench
===========================

# fifo_buf

Eight-entry synchronous FIFO that consumes the 3-bit wrapping write/read pointer scheme used by the pointer counter stage. It holds the storage array, derives full/empty/occupancy from the pointer pair plus wrap-phase bits, and presents registered read data. It sits directly downstream of the pointer counters in the FIFO datapath and is the block the producer and consumer logic talk to.

## Interface

Parameters:
- WIDTH, 8, data word width in bits (depth fixed at 8 entries, 3-bit pointers)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  push request for current cycle
- din  input  WIDTH  write data, sampled with wr_en
- rd_en  input  1  pop request for current cycle
- dout  output  WIDTH  registered read data
- full  output  1  8 entries held
- empty  output  1  0 entries held
- count  output  4  occupancy, 0..8
- ovf  output  1  sticky: push attempted while full
- udf  output  1  sticky: pop attempted while empty

## Operation

- State: wr_ptr[2:0], wr_ph, rd_ptr[2:0], rd_ph, mem[0:7] of WIDTH, dout register, ovf, udf.
- Pointers advance by 1 mod 8; on 7->0 wrap the matching phase bit toggles (phase = carry-out of the pointer).
- Push accepted iff wr_en && !full: mem[wr_ptr] <= din, wr_ptr/wr_ph advance.
- Pop accepted iff rd_en && !empty: dout <= mem[rd_ptr], rd_ptr/rd_ph advance.
- Acceptance uses current-cycle full/empty only. When full, a push is rejected even if a pop is accepted in the same cycle. When empty, a pop is rejected even if a push is accepted in the same cycle.
- Simultaneous accepted push and pop (1..7 entries): both occur, count unchanged.
- Flags and count decode combinationally from pointer registers only, with no input-to-output path:
  - empty = (wr_ptr == rd_ptr) && (wr_ph == rd_ph)
  - full = (wr_ptr == rd_ptr) && (wr_ph != rd_ph)
  - count = {wr_ph,wr_ptr} - {rd_ph,rd_ptr}, taken mod 16; always 0..8
- ovf set on wr_en && full; udf set on rd_en && empty. Both cleared only by reset.
- Rejected requests change no pointer, mem entry or dout.
- dout holds its last value when no pop is accepted.
- Reset values: pointers 0, phases 0, dout 0, ovf 0, udf 0, therefore empty=1, full=0, count=0. mem is not reset.
- Reset has priority over wr_en/rd_en in the same cycle. A mid-operation reset discards all contents.

## Timing

- Push at edge N: count/empty/full reflect it after edge N. The earliest pop is sampled at edge N+1, and that data appears on dout after edge N+1.
- Read latency: 1 cycle from the sampling edge of an accepted pop to dout valid.
- Back-to-back pops at 1 per cycle deliver consecutive entries on consecutive cycles.
- Sticky flags assert after the edge that sampled the offending request.
- Reset asserted at edge R: all outputs at reset values after edge R. First push accepted at the first edge with reset low.

## Test plan

- Reset, then 8 pushes of 0x11..0x88 with no pops -> count steps 1..8, full=1 after the 8th edge, empty=0, ovf=0.
- Full FIFO, 9th push of 0x99 -> ovf=1 sticky, count stays 8, contents unchanged. Then 8 pops -> dout 0x11..0x88 in order, one per cycle, empty=1 at the end.
- Empty FIFO, pop -> udf=1, dout unchanged, count 0. A later push plus pop still work normally.
- Wrap: push/pop 12 words (0x01..0x0C) keeping occupancy at 3 -> pointers cross 7->0, phase bits toggle, data order preserved, full never asserts.
- Simultaneous push+pop at count=4 -> count stays 4. At count=8 (push 0xAA, pop) -> pop accepted, push rejected, ovf=1, count=7. At count=0 (push 0xBB, pop) -> push accepted, pop rejected, udf=1, count=1.
- Reset asserted with count=5 and ovf=1, wr_en=rd_en=1 -> after that edge: count=0, empty=1, ovf=udf=0, dout=0.

Source files
------------

// File: rtl/fifo_buf_if.sv
// Handshake and status bundle between a producer/consumer and the eight-entry
// fifo_buf. The master drives requests and write data; the slave returns read data and status.
interface fifo_buf_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             ovf;
  logic             udf;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, count, ovf, udf
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_buf.sv
// Eight-entry synchronous FIFO with wrapping 3-bit pointers and phase bits.
// Read data is registered; status decodes from the pointer registers alone.
module fifo_buf #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       reset,
  fifo_buf_if.slave bus
);

  logic [2:0]       wr_ptr_r;
  logic             wr_ph_r;
  logic [2:0]       rd_ptr_r;
  logic             rd_ph_r;
  logic [WIDTH-1:0] mem_r [8];
  logic [WIDTH-1:0] dout_r;
  logic             ovf_r;
  logic             udf_r;

  logic             full_s;
  logic             empty_s;
  logic [3:0]       count_s;
  logic             push_s;
  logic             pop_s;

  // Status decode and request acceptance from the current pointer state.
  always_comb begin
    full_s  = 1'b0;
    empty_s = 1'b0;
    count_s = 4'd0;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = (wr_ph_r == rd_ph_r);
      full_s  = (wr_ph_r != rd_ph_r);
    end else begin
      empty_s = 1'b0;
      full_s  = 1'b0;
    end
    // The phase bit acts as the pointer carry, so this difference is always 0..8.
    count_s = {wr_ph_r, wr_ptr_r} - {rd_ph_r, rd_ptr_r};
    push_s  = bus.wr_en && !full_s;
    pop_s   = bus.rd_en && !empty_s;
  end

  // Pointer, read-data and sticky error registers; reset wins over requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= 3'd0;
      wr_ph_r  <= 1'b0;
      rd_ptr_r <= 3'd0;
      rd_ph_r  <= 1'b0;
      dout_r   <= {WIDTH{1'b0}};
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        {wr_ph_r, wr_ptr_r} <= {wr_ph_r, wr_ptr_r} + 4'd1;
      end
      if (pop_s) begin
        {rd_ph_r, rd_ptr_r} <= {rd_ph_r, rd_ptr_r} + 4'd1;
        dout_r              <= mem_r[rd_ptr_r];
      end
      if (bus.wr_en && full_s) begin
        ovf_r <= 1'b1;
      end
      if (bus.rd_en && empty_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= bus.din;
    end
  end

  assign bus.dout  = dout_r;
  assign bus.full  = full_s;
  assign bus.empty = empty_s;
  assign bus.count = count_s;
  assign bus.ovf   = ovf_r;
  assign bus.udf   = udf_r;

endmodule

// File: tb/tb_fifo_buf.sv
// Directed bench for fifo_buf: a queue model tracks contents and status, expected
// pop data goes to a scoreboard queue that a separate monitor drains against dout.
module tb_fifo_buf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_buf_if #(.WIDTH(8)) bus ();

  fifo_buf #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       movf;
  logic       mudf;
  logic [7:0] mdout;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic rst);
    bit was_full, was_empty, push_ok, pop_ok;
    was_full  = (mq.size() == 8);
    was_empty = (mq.size() == 0);
    push_ok   = w && !was_full;
    pop_ok    = r && !was_empty;
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
    reset     = rst;
    if (!rst && pop_ok) exp_q.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      movf  = 1'b0;
      mudf  = 1'b0;
      mdout = 8'h00;
    end else begin
      if (w && was_full) movf = 1'b1;
      if (r && was_empty) mudf = 1'b1;
      if (pop_ok) mdout = mq.pop_front();
      if (push_ok) mq.push_back(d);
    end
    check("count", int'(bus.count), mq.size());
    check("full", int'(bus.full), int'(mq.size() == 8));
    check("empty", int'(bus.empty), int'(mq.size() == 0));
    check("ovf", int'(bus.ovf), int'(movf));
    check("udf", int'(bus.udf), int'(mudf));
    if (rst || !pop_ok) check("dout_hold", int'(bus.dout), int'(mdout));
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    reset     = 1'b0;
  endtask

  // Monitor: a pop the DUT accepts must show the next scoreboard entry after the edge.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = bus.rd_en && !bus.empty && !reset;
      @(posedge clk);
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_scoreboard: pop accepted with dout 0x%0h, expected no pop", bus.dout);
        end else begin
          check("dout_scoreboard", int'(bus.dout), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.din   = 8'h00;
    bus.rd_en = 1'b0;
    reset     = 1'b1;
    movf      = 1'b0;
    mudf      = 1'b0;
    mdout     = 8'h00;

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Fill with 0x11..0x88, then overflow attempt with 0x99.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i * 17), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow on empty, then normal push and pop.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap with occupancy held at 3.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 4; i <= 12; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push+pop at counts 4, 8 and 0.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h25, 1'b1, 1'b0);
    for (int i = 6; i <= 9; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);

    // Reach count 5 with ovf set, then reset under wr_en/rd_en.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 1'b1);

    // First edge after reset accepts a push.
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
